// File: rtl/elbeth_mem_arbiter.sv
// rtl/elbeth_mem_arbiter.sv - fetch/data arbiter for one shared single-ported memory bus
module elbeth_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DMEM_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_en,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [3:0]        imem_wr,
  output logic [DATA_W-1:0] imem_r_data,
  output logic              imem_ready,
  output logic              imem_error,
  input  logic              dmem_en,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [3:0]        dmem_wr,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic              dmem_error,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic              mem_ready,
  input  logic              mem_error
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_DMEM_STREAK);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] streak;
  logic [7:0] timer;
  logic       grant_d, grant_i, timeout, done;

  // Read data is shared; only the ready strobe tells a requester it is meaningful.
  assign imem_r_data = mem_r_data;
  assign dmem_r_data = mem_r_data;

  // Arbitration decision, watchdog detection and next-state selection.
  always_comb begin
    grant_d    = dmem_en && !(imem_en && (streak == STREAK_MAX));
    grant_i    = !grant_d && imem_en;
    timeout    = (timer == TIMEOUT_LAST) && !mem_ready && !mem_error;
    done       = mem_ready || mem_error || timeout;
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request and completion routing to the granted requester only.
  always_comb begin
    mem_en     = (state == BUSY_I) || (state == BUSY_D);
    imem_ready = (state == BUSY_I) && mem_ready;
    imem_error = (state == BUSY_I) && (mem_error || timeout);
    dmem_ready = (state == BUSY_D) && mem_ready;
    dmem_error = (state == BUSY_D) && (mem_error || timeout);
  end

  // State register plus latched request, streak counter and watchdog timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      streak     <= 4'd0;
      timer      <= 8'd0;
      mem_addr   <= '0;
      mem_wr     <= 4'd0;
      mem_w_data <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        timer <= 8'd0;
        if (grant_d) begin
          mem_addr   <= dmem_addr;
          mem_wr     <= dmem_wr;
          mem_w_data <= dmem_w_data;
          // Count only data grants that made a waiting fetch wait longer.
          if (imem_en) streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
          else         streak <= 4'd0;
        end else if (grant_i) begin
          mem_addr   <= imem_addr;
          mem_wr     <= imem_wr;
          mem_w_data <= '0;
          streak     <= 4'd0;
        end
      end else begin
        timer <= done ? 8'd0 : timer + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// tb/tb_elbeth_mem_arbiter.sv - directed self-checking bench for elbeth_mem_arbiter
module tb_elbeth_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [3:0]  imem_wr;
  logic [31:0] imem_r_data;
  logic        imem_ready, imem_error;
  logic        dmem_en;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wr;
  logic [31:0] dmem_w_data;
  logic [31:0] dmem_r_data;
  logic        dmem_ready, dmem_error;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic        mem_ready, mem_error;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] IADDR = 32'h0000_0100;
  localparam logic [31:0] DADDR = 32'h2000_0004;

  elbeth_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_wr(imem_wr),
    .imem_r_data(imem_r_data), .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wr(dmem_wr), .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .mem_ready(mem_ready), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b0;
    imem_en = 0; imem_addr = IADDR; imem_wr = 4'd0;
    dmem_en = 0; dmem_addr = DADDR; dmem_wr = 4'hF; dmem_w_data = 32'hDEAD_BEEF;
    mem_r_data = 32'd0; mem_ready = 0; mem_error = 0;
    tick(); tick();
    check("reset_mem_en", {31'd0, mem_en}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_w_data", mem_w_data, 32'd0);
    check("reset_readies", {28'd0, imem_ready, imem_error, dmem_ready, dmem_error}, 32'd0);
    rst = 1'b1;

    // single fetch, ready on third busy cycle
    imem_en = 1;
    tick();
    check("fetch_mem_en", {31'd0, mem_en}, 32'd1);
    check("fetch_mem_addr", mem_addr, IADDR);
    check("fetch_mem_wr", {28'd0, mem_wr}, 32'd0);
    check("fetch_mem_w_data", mem_w_data, 32'd0);
    tick();
    tick();
    check("fetch_no_early_ready", {31'd0, imem_ready}, 32'd0);
    mem_ready = 1; mem_r_data = 32'h0000_0013;
    #1;
    check("fetch_ready", {31'd0, imem_ready}, 32'd1);
    check("fetch_r_data", imem_r_data, 32'h13);
    check("fetch_dmem_ready_quiet", {31'd0, dmem_ready}, 32'd0);
    imem_en = 0;
    tick();
    mem_ready = 0;
    #1;
    check("fetch_idle_mem_en", {31'd0, mem_en}, 32'd0);
    check("fetch_ready_pulse", {31'd0, imem_ready}, 32'd0);

    // simultaneous request: data wins, fetch after one idle cycle
    imem_en = 1; dmem_en = 1;
    tick();
    check("sim_d_addr", mem_addr, DADDR);
    check("sim_d_wr", {28'd0, mem_wr}, 32'hF);
    check("sim_d_wdata", mem_w_data, 32'hDEAD_BEEF);
    mem_ready = 1;
    #1;
    check("sim_d_ready", {30'd0, dmem_ready, imem_ready}, 32'd2);
    dmem_en = 0;
    tick();
    mem_ready = 0;
    #1;
    check("sim_gap_idle", {31'd0, mem_en}, 32'd0);
    tick();
    check("sim_i_addr", mem_addr, IADDR);
    check("sim_i_wdata", mem_w_data, 32'd0);
    mem_ready = 1;
    #1;
    check("sim_i_ready", {30'd0, dmem_ready, imem_ready}, 32'd1);
    imem_en = 0;
    tick();
    mem_ready = 0;

    // starvation guard: both held, single-cycle memory
    imem_en = 1; dmem_en = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("starve_grant_%0d", k), mem_addr, exp_i[k] ? IADDR : DADDR);
      mem_ready = 1;
      #1;
      check($sformatf("starve_ready_%0d", k), {30'd0, dmem_ready, imem_ready},
            exp_i[k] ? 32'd1 : 32'd2);
      tick();
      mem_ready = 0;
    end
    imem_en = 0; dmem_en = 0;
    tick();

    // bus error on fetch
    imem_en = 1;
    tick();
    mem_error = 1;
    #1;
    check("err_imem_error", {28'd0, imem_ready, imem_error, dmem_ready, dmem_error}, 32'h4);
    imem_en = 0;
    tick();
    mem_error = 0;
    #1;
    check("err_pulse_end", {31'd0, imem_error}, 32'd0);
    check("err_idle", {31'd0, mem_en}, 32'd0);

    // watchdog on data read with no response
    dmem_en = 1; dmem_wr = 4'd0;
    tick();
    for (int k = 0; k < 253; k++) tick();
    check("to_no_error_254", {31'd0, dmem_error}, 32'd0);
    check("to_busy_254", {31'd0, mem_en}, 32'd1);
    tick();
    check("to_error_255", {28'd0, imem_ready, imem_error, dmem_ready, dmem_error}, 32'h1);
    dmem_en = 0;
    tick();
    check("to_mem_en_drop", {31'd0, mem_en}, 32'd0);
    mem_ready = 1;
    #1;
    check("to_late_ready_ignored", {28'd0, imem_ready, imem_error, dmem_ready, dmem_error}, 32'd0);
    tick();
    mem_ready = 0;

    // reset in the middle of a data transfer with ready pending
    dmem_en = 1; dmem_wr = 4'hF;
    tick();
    check("rst_busy_before", {31'd0, mem_en}, 32'd1);
    mem_ready = 1; rst = 0;
    #1;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_dmem_ready", {31'd0, dmem_ready}, 32'd0);
    mem_ready = 0; dmem_en = 0; imem_en = 1;
    tick();
    rst = 1;
    tick();
    check("rst_regrant_en", {31'd0, mem_en}, 32'd1);
    check("rst_regrant_addr", mem_addr, IADDR);
    imem_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elbeth_mem_arbiter.md
Name: elbeth_mem_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction-fetch port (imem_*) and data port (dmem_*). The block sits between the core and the unified memory/bus adapter. It grants one requester at a time, latches that request, and routes ready/error/read-data back to the granted requester only. It gives the data port priority, bounded by a starvation guard for fetch, and terminates hung transfers with a watchdog timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DMEM_STREAK, 4, maximum consecutive dmem grants while imem waits (1..15)
TIMEOUT_CYCLES, 255, cycles in a busy state without mem_ready/mem_error before forced error (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_en  in  1  fetch request; held with imem_addr stable until imem_ready or imem_error
imem_addr  in  ADDR_W  fetch address
imem_wr  in  4  fetch byte write-enables (normally 0)
imem_r_data  out  DATA_W  fetch read data
imem_ready  out  1  fetch completion pulse
imem_error  out  1  fetch error pulse
dmem_en  in  1  data request; held with addr/wr/w_data stable until dmem_ready or dmem_error
dmem_addr  in  ADDR_W  data address
dmem_wr  in  4  byte write-enables; 0 = read
dmem_w_data  in  DATA_W  write data
dmem_r_data  out  DATA_W  data read data
dmem_ready  out  1  data completion pulse
dmem_error  out  1  data error pulse
mem_en  out  1  bus request
mem_addr  out  ADDR_W  bus address (registered)
mem_wr  out  4  bus byte write-enables (registered)
mem_w_data  out  DATA_W  bus write data (registered)
mem_r_data  in  DATA_W  bus read data
mem_ready  in  1  bus completion, one cycle
mem_error  in  1  bus error, one cycle

Behaviour:
- FSM states are IDLE, BUSY_I and BUSY_D. Reset (rst=0, async) forces IDLE, streak=0 and timer=0. Reset also drives mem_en=0, mem_addr=0, mem_wr=0, mem_w_data=0 and all requester ready/error=0, and it discards any in-flight transfer.
- In IDLE, mem_en=0. Arbitration runs on the clock edge:
  - If dmem_en=1, and not (imem_en=1 and streak==MAX_DMEM_STREAK): grant D. Latch dmem_addr/wr/w_data into mem_*. Go to BUSY_D. If imem_en=1, streak+=1; otherwise streak=0.
  - Else if imem_en=1: grant I. Latch imem_addr/imem_wr into mem_*, with mem_w_data=0. Go to BUSY_I. Set streak=0.
  - Else stay in IDLE.
- In BUSY_x, mem_en=1 and mem_* hold the latched values. The timer increments every cycle.
- Completion in BUSY_x, when mem_ready=1 or mem_error=1:
  - x_ready=mem_ready and x_error=mem_error, combinational, in the same cycle.
  - Both inputs high: the requester sees both; the requester treats error as dominant.
  - Next state is IDLE, timer=0. mem_en is 0 in the following cycle.
- Timeout: if the timer reaches TIMEOUT_CYCLES-1 in BUSY_x with no mem_ready/mem_error, x_error=1 for that cycle and the next state is IDLE. A late mem_ready arriving in IDLE is ignored.
- The non-granted requester never sees ready/error. imem_r_data and dmem_r_data are a direct copy of mem_r_data and are valid only when the matching ready=1.
- Latency: request sampled in IDLE at edge N → mem_en=1 from cycle N+1. The minimum transaction is 2 cycles (grant cycle plus 1 busy cycle with mem_ready=1). There is always at least one IDLE cycle between transactions.
- Requester en dropped while granted: the transfer still completes on the bus and the ready pulse is still issued. The requester ignores it.
- Ready and error are never asserted outside BUSY_x.
- Streak saturates at MAX_DMEM_STREAK. It resets to 0 on any I grant, and on a D grant when imem_en=0.

Test Plan:
- Reset idle: rst=0 mid-BUSY_D with mem_ready pending → mem_en=0 immediately and all outputs 0. After rst=1, the first request is granted normally.
- Single fetch: imem_en=1, addr=0x0000_0100, mem_ready on the 3rd busy cycle with r_data=0x0000_0013 → mem_addr=0x100 and mem_wr=0. imem_ready pulses 1 cycle with imem_r_data=0x13. dmem_ready stays 0.
- Simultaneous request: imem_en=dmem_en=1, dmem_addr=0x2000_0004, wr=4'b1111, w_data=0xDEADBEEF → D is granted first with mem_w_data=0xDEADBEEF. I is granted after 1 IDLE cycle.
- Starvation guard: dmem_en and imem_en held continuously, memory ready in 1 cycle → grant order D,D,D,D,I,D,D,D,D,I.
- Error and timeout: mem_error=1 in BUSY_I → imem_error=1 for 1 cycle. Then dmem read with no mem_ready → dmem_error pulses at busy cycle 255 and mem_en drops the next cycle.
